// File: rtl/miriscv_irq_pkg.sv
// Shared types and constants for the miriscv interrupt controller.
// Contents: FSM state enum, mcause interrupt flag position, default sizes.
package miriscv_irq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SERVICE,
        FIN,
        GUARD
    } irq_state_t;

    localparam int MCAUSE_INT_BIT  = 31;
    localparam int IRQ_NUM_DEF     = 32;
    localparam int MCAUSE_BASE_DEF = 16;

endpackage

// File: rtl/miriscv_prio_enc.sv
// Lowest-index-first priority encoder (purely combinational).
// Ports: req_i request vector; valid_o any bit set; idx_o winning index.
module miriscv_prio_enc #(
    parameter int N  = 32,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    // Scan downward so the lowest set index is written last and wins.
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/miriscv_irq_ctrl.sv
// Fixed-priority, non-nesting interrupt controller in front of the core.
// Ports: clk_i, rst_n_i (sync, active-low), int_req_i, mie_i,
//   mstatus_mie_i, irq_ack_i, mret_i -> irq_o, mcause_o, int_fin_o.
module miriscv_irq_ctrl
    import miriscv_irq_pkg::*;
#(
    parameter int IRQ_NUM     = IRQ_NUM_DEF,
    parameter int MCAUSE_BASE = MCAUSE_BASE_DEF
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [IRQ_NUM-1:0] int_req_i,
    input  logic [IRQ_NUM-1:0] mie_i,
    input  logic               mstatus_mie_i,
    input  logic               irq_ack_i,
    input  logic               mret_i,
    output logic               irq_o,
    output logic [31:0]        mcause_o,
    output logic [IRQ_NUM-1:0] int_fin_o
);

    localparam int IW = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

    irq_state_t state_q, state_d;

    logic [IW-1:0]      id_q, id_d;
    logic               irq_q, irq_d;
    logic [31:0]        mcause_q, mcause_d;
    logic [IRQ_NUM-1:0] fin_q, fin_d;

    logic [IRQ_NUM-1:0] pending;
    logic               cand_vld;
    logic [IW-1:0]      cand_idx;
    logic [30:0]        cand_code;

    assign pending   = int_req_i & mie_i;
    assign cand_code = 31'(MCAUSE_BASE) + 31'(cand_idx);

    miriscv_prio_enc #(
        .N  (IRQ_NUM),
        .IW (IW)
    ) u_prio_enc (
        .req_i   (pending),
        .valid_o (cand_vld),
        .idx_o   (cand_idx)
    );

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        irq_d    = irq_q;
        mcause_d = mcause_q;
        fin_d    = '0;

        unique case (state_q)
            IDLE: begin
                if (mstatus_mie_i && cand_vld) begin
                    id_d                     = cand_idx;
                    mcause_d                 = '0;
                    mcause_d[30:0]           = cand_code;
                    mcause_d[MCAUSE_INT_BIT] = 1'b1;
                    irq_d                    = 1'b1;
                    state_d                  = REQ;
                end
            end
            // Request is latched: mask or source changes cannot withdraw it,
            // and an mret here belongs to no trap of ours.
            REQ: begin
                if (irq_ack_i) begin
                    irq_d   = 1'b0;
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (mret_i) begin
                    fin_d[id_q] = 1'b1;
                    state_d     = FIN;
                end
            end
            FIN: begin
                state_d = GUARD;
            end
            // Gives the finished source a cycle to drop its level request.
            GUARD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            id_q     <= '0;
            irq_q    <= 1'b0;
            mcause_q <= '0;
            fin_q    <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            irq_q    <= irq_d;
            mcause_q <= mcause_d;
            fin_q    <= fin_d;
        end
    end

    assign irq_o     = irq_q;
    assign mcause_o  = mcause_q;
    assign int_fin_o = fin_q;

endmodule

// File: tb/tb_miriscv_irq_ctrl.sv
// Directed self-checking bench for miriscv_irq_ctrl.
// Drives and samples 1 time unit after each rising edge.
module tb_miriscv_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] req;
    logic [31:0] mie;
    logic        gie;
    logic        ack;
    logic        mret;
    logic        irq;
    logic [31:0] mcause;
    logic [31:0] fin;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    miriscv_irq_ctrl #(
        .IRQ_NUM     (32),
        .MCAUSE_BASE (16)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .int_req_i     (req),
        .mie_i         (mie),
        .mstatus_mie_i (gie),
        .irq_ack_i     (ack),
        .mret_i        (mret),
        .irq_o         (irq),
        .mcause_o      (mcause),
        .int_fin_o     (fin)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic pulse_mret();
        mret = 1'b1;
        step();
        mret = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 32'hFFFF_FFFF;
        mie   = 32'hFFFF_FFFF;
        gie   = 1'b1;
        ack   = 1'b0;
        mret  = 1'b0;

        // reset held with every source requesting
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_irq", {31'd0, irq}, 32'd0);
            chk("rst_mcause", mcause, 32'd0);
            chk("rst_fin", fin, 32'd0);
        end
        rst_n = 1'b1;
        step();
        chk("rel_irq", {31'd0, irq}, 32'd1);
        chk("rel_mcause", mcause, 32'h8000_0010);
        pulse_ack();
        pulse_mret();
        chk("rel_fin", fin, 32'h1);
        req = 32'h0;
        step();
        step();

        // single source 5
        req = 32'h20;
        step();
        chk("s_irq", {31'd0, irq}, 32'd1);
        chk("s_mcause", mcause, 32'h8000_0015);
        pulse_ack();
        chk("s_ack_irq", {31'd0, irq}, 32'd0);
        pulse_mret();
        chk("s_fin", fin, 32'h20);
        req = 32'h0;
        step();
        chk("s_fin_clr", fin, 32'h0);
        step();
        step();
        chk("s_idle_irq", {31'd0, irq}, 32'd0);
        chk("s_mcause_hold", mcause, 32'h8000_0015);

        // two pending: 4 before 7
        req = 32'h90;
        step();
        chk("p_mcause0", mcause, 32'h8000_0014);
        pulse_ack();
        pulse_mret();
        chk("p_fin0", fin, 32'h10);
        req = 32'h80;
        step();
        chk("p_guard_irq", {31'd0, irq}, 32'd0);
        step();
        chk("p_idle_irq", {31'd0, irq}, 32'd0);
        step();
        chk("p_irq1", {31'd0, irq}, 32'd1);
        chk("p_mcause1", mcause, 32'h8000_0017);
        pulse_ack();
        pulse_mret();
        chk("p_fin1", fin, 32'h80);
        req = 32'h0;
        step();
        step();

        // masking
        mie = 32'hFFFF_FFF7;
        req = 32'h8;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("m_mie_irq", {31'd0, irq}, 32'd0);
        end
        mie = 32'hFFFF_FFFF;
        gie = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("m_gie_irq", {31'd0, irq}, 32'd0);
        end
        gie = 1'b1;
        step();
        chk("m_irq", {31'd0, irq}, 32'd1);
        chk("m_mcause", mcause, 32'h8000_0013);

        // ignored events while in REQ / SERVICE
        pulse_mret();
        chk("i_mret_irq", {31'd0, irq}, 32'd1);
        chk("i_mret_fin", fin, 32'h0);
        req = 32'h0;
        step();
        chk("i_drop_irq", {31'd0, irq}, 32'd1);
        ack  = 1'b1;
        mret = 1'b1;
        step();
        ack  = 1'b0;
        mret = 1'b0;
        chk("i_both_irq", {31'd0, irq}, 32'd0);
        chk("i_both_fin", fin, 32'h0);
        step();
        chk("i_svc_fin", fin, 32'h0);
        pulse_ack();
        chk("i_sack_irq", {31'd0, irq}, 32'd0);
        chk("i_sack_fin", fin, 32'h0);
        pulse_mret();
        chk("i_fin", fin, 32'h8);
        step();
        step();

        // reset while in SERVICE
        req = 32'h2;
        step();
        chk("r_mcause", mcause, 32'h8000_0011);
        pulse_ack();
        rst_n = 1'b0;
        mret  = 1'b1;
        step();
        mret = 1'b0;
        chk("r_fin", fin, 32'h0);
        chk("r_irq", {31'd0, irq}, 32'd0);
        chk("r_mcause0", mcause, 32'h0);
        step();
        chk("r_fin2", fin, 32'h0);
        rst_n = 1'b1;
        step();
        chk("r_irq2", {31'd0, irq}, 32'd1);
        chk("r_mcause2", mcause, 32'h8000_0011);
        chk("r_fin3", fin, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
